hpdcache_sram_wbe_ctrl: RTL and testbench

//   Initiator-side controller for a 1RW SRAM macro with per-byte write enable and 1-cycle read latency.

---
 rtl/hpdcache_sram_wbe_ctrl_if.sv | 37 +++
 rtl/hpdcache_sram_wbe_ctrl.sv | 112 +++++++++++
 tb/tb_hpdcache_sram_wbe_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hpdcache_sram_wbe_ctrl_if.sv
// Request, response and SRAM strobe bundle for the 1RW byte-enable SRAM controller.
// The slave modport is the controller's view; the master modport is the client/SRAM side.
interface hpdcache_sram_wbe_ctrl_if #(
    parameter int ADDR_SIZE = 6,
    parameter int DATA_SIZE = 64
);
    logic                     req_valid_i;
    logic                     req_ready_o;
    logic                     req_we_i;
    logic [ADDR_SIZE-1:0]     req_addr_i;
    logic [DATA_SIZE-1:0]     req_wdata_i;
    logic [DATA_SIZE/8-1:0]   req_be_i;
    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [DATA_SIZE-1:0]     rsp_rdata_o;
    logic                     init_done_o;
    logic                     sram_cs_o;
    logic                     sram_we_o;
    logic [ADDR_SIZE-1:0]     sram_addr_o;
    logic [DATA_SIZE-1:0]     sram_wdata_o;
    logic [DATA_SIZE/8-1:0]   sram_wbyteenable_o;
    logic [DATA_SIZE-1:0]     sram_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
        input  rsp_ready_i, sram_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, init_done_o,
        output sram_cs_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_wbyteenable_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i,
        output rsp_ready_i, sram_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, init_done_o,
        input  sram_cs_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_wbyteenable_o
    );
endinterface

// File: rtl/hpdcache_sram_wbe_ctrl.sv
// Initiator-side controller for a 1RW byte-enable SRAM with 1-cycle read latency:
// optional zero-fill after reset, credit-limited reads and a 2-entry response FIFO.
module hpdcache_sram_wbe_ctrl #(
    parameter int ADDR_SIZE     = 6,
    parameter int DATA_SIZE     = 64,
    parameter int DEPTH         = 2**ADDR_SIZE,
    parameter int INIT_ON_RESET = 1
) (
    input  logic clk,
    input  logic rst_n,
    hpdcache_sram_wbe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_RST, ST_INIT, ST_RUN} state_e;

    state_e                 state;
    logic [ADDR_SIZE-1:0]   init_cnt;
    logic [1:0]             credits;
    logic [1:0]             credits_next;
    logic                   rd_pend;
    logic [DATA_SIZE-1:0]   fifo_mem [2];
    logic                   fifo_wptr;
    logic                   fifo_rptr;
    logic [1:0]             fifo_cnt;
    logic                   fifo_empty;
    logic                   accept;
    logic                   read_accept;
    logic                   pop;
    logic                   push;
    logic                   fifo_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RST;
            init_cnt <= '0;
        end else begin
            case (state)
                ST_RST:  state <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
                ST_INIT: begin
                    if (init_cnt == ADDR_SIZE'(DEPTH - 1)) begin
                        state <= ST_RUN;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_RST;
            endcase
        end
    end

    always_comb begin
        bus.req_ready_o = (state == ST_RUN) && (credits < 2'd2);
        bus.init_done_o = (state == ST_RUN);
        accept          = bus.req_valid_i & bus.req_ready_o;
        read_accept     = accept & ~bus.req_we_i;
    end

    // The fill sequence owns the SRAM port; otherwise only an accepted request drives it.
    always_comb begin
        bus.sram_cs_o          = 1'b0;
        bus.sram_we_o          = 1'b0;
        bus.sram_addr_o        = '0;
        bus.sram_wdata_o       = '0;
        bus.sram_wbyteenable_o = '0;
        if (state == ST_INIT) begin
            bus.sram_cs_o          = 1'b1;
            bus.sram_we_o          = 1'b1;
            bus.sram_addr_o        = init_cnt;
            bus.sram_wbyteenable_o = '1;
        end else if (accept) begin
            bus.sram_cs_o          = 1'b1;
            bus.sram_we_o          = bus.req_we_i;
            bus.sram_addr_o        = bus.req_addr_i;
            bus.sram_wdata_o       = bus.req_wdata_i;
            bus.sram_wbyteenable_o = bus.req_be_i;
        end
    end

    // Empty FIFO with a read in flight bypasses the SRAM data straight to the response port.
    always_comb begin
        fifo_empty      = (fifo_cnt == 2'd0);
        bus.rsp_valid_o = !fifo_empty || rd_pend;
        bus.rsp_rdata_o = fifo_empty ? bus.sram_rdata_i : fifo_mem[fifo_rptr];
        pop             = bus.rsp_valid_o & bus.rsp_ready_i;
        fifo_pop        = pop & !fifo_empty;
        push            = rd_pend & !(fifo_empty & pop);
        credits_next    = credits + 2'(read_accept) - 2'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits     <= '0;
            rd_pend     <= 1'b0;
            fifo_wptr   <= 1'b0;
            fifo_rptr   <= 1'b0;
            fifo_cnt    <= '0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            credits <= credits_next;
            rd_pend <= read_accept;
            if (push) begin
                fifo_mem[fifo_wptr] <= bus.sram_rdata_i;
                fifo_wptr           <= ~fifo_wptr;
            end
            if (fifo_pop) begin
                fifo_rptr <= ~fifo_rptr;
            end
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(fifo_pop);
        end
    end
endmodule

// File: tb/tb_hpdcache_sram_wbe_ctrl.sv
// Directed bench for hpdcache_sram_wbe_ctrl with a behavioural byte-enable SRAM model.
module tb_hpdcache_sram_wbe_ctrl;
    localparam int ADDR_SIZE = 6;
    localparam int DATA_SIZE = 64;
    localparam int DEPTH     = 64;
    localparam logic [63:0] D10 = 64'hA0A1A2A3A4A5A6A7;
    localparam logic [63:0] D11 = 64'hB0B1B2B3B4B5B6B7;
    localparam logic [63:0] D12 = 64'hC0C1C2C3C4C5C6C7;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [63:0] sram_mem [DEPTH];

    hpdcache_sram_wbe_ctrl_if #(.ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE)) bus ();

    hpdcache_sram_wbe_ctrl #(
        .ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH), .INIT_ON_RESET(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro model: byte-masked write, registered read data.
    always @(posedge clk) begin
        logic [63:0] word;
        if (bus.sram_cs_o) begin
            if (bus.sram_we_o) begin
                word = sram_mem[bus.sram_addr_o];
                for (int b = 0; b < 8; b++)
                    if (bus.sram_wbyteenable_o[b]) word[8*b +: 8] = bus.sram_wdata_o[8*b +: 8];
                sram_mem[bus.sram_addr_o] <= word;
            end else begin
                bus.sram_rdata_i <= sram_mem[bus.sram_addr_o];
            end
        end
    end

    task automatic drive_idle();
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.req_be_i    = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        bus.rsp_ready_i  = 1'b1;
        bus.sram_rdata_i = '0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({bus.sram_cs_o, bus.sram_we_o, bus.rsp_valid_o, bus.req_ready_o, bus.init_done_o} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got cs/we/rv/rdy/done=%b required 00000",
                     {bus.sram_cs_o, bus.sram_we_o, bus.rsp_valid_o, bus.req_ready_o, bus.init_done_o});
        end
        n_tests++;
        if ({bus.sram_addr_o, bus.sram_wdata_o, bus.sram_wbyteenable_o} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_bus: got addr=%h wdata=%h be=%h required 0",
                     bus.sram_addr_o, bus.sram_wdata_o, bus.sram_wbyteenable_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if ({bus.sram_cs_o, bus.req_ready_o, bus.init_done_o} !== 3'b0) begin
            n_fail++;
            $display("[TB] FAIL post_release: got cs/rdy/done=%b required 000",
                     {bus.sram_cs_o, bus.req_ready_o, bus.init_done_o});
        end
    endtask

    task automatic test_init_fill();
        int bad;
        bad = 0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            #1;
            if (!(bus.sram_cs_o === 1'b1 && bus.sram_we_o === 1'b1 && bus.sram_addr_o === 6'(k) &&
                  bus.sram_wdata_o === 64'h0 && bus.sram_wbyteenable_o === 8'hFF &&
                  bus.req_ready_o === 1'b0 && bus.init_done_o === 1'b0)) begin
                if (bad == 0)
                    $display("[TB] FAIL init_fill: cycle %0d got cs=%b we=%b addr=%0d be=%h rdy=%b done=%b required addr=%0d be=ff",
                             k, bus.sram_cs_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_wbyteenable_o,
                             bus.req_ready_o, bus.init_done_o, k);
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) n_fail++;
        @(negedge clk);
        #1;
        n_tests++;
        if ({bus.init_done_o, bus.req_ready_o, bus.sram_cs_o} !== 3'b110) begin
            n_fail++;
            $display("[TB] FAIL init_done: got done/rdy/cs=%b required 110",
                     {bus.init_done_o, bus.req_ready_o, bus.sram_cs_o});
        end
    endtask

    task automatic test_write_read();
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b1;
        bus.req_addr_i  = 6'd5;
        bus.req_wdata_i = 64'h1122334455667788;
        bus.req_be_i    = 8'h0F;
        #1;
        n_tests++;
        if ({bus.sram_cs_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_wbyteenable_o, bus.sram_wdata_o} !==
            {1'b1, 1'b1, 6'd5, 8'h0F, 64'h1122334455667788}) begin
            n_fail++;
            $display("[TB] FAIL write_strobe: got cs=%b we=%b addr=%0d be=%h wdata=%h required 1 1 5 0f 1122334455667788",
                     bus.sram_cs_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_wbyteenable_o, bus.sram_wdata_o);
        end
        @(negedge clk);
        bus.req_we_i = 1'b0;
        #1;
        n_tests++;
        if ({bus.sram_cs_o, bus.sram_we_o, bus.sram_addr_o} !== {1'b1, 1'b0, 6'd5}) begin
            n_fail++;
            $display("[TB] FAIL read_strobe: got cs=%b we=%b addr=%0d required 1 0 5",
                     bus.sram_cs_o, bus.sram_we_o, bus.sram_addr_o);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_tests++;
        if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== 64'h0000000055667788) begin
            n_fail++;
            $display("[TB] FAIL partial_write_read: got valid=%b data=%h required 1 0000000055667788",
                     bus.rsp_valid_o, bus.rsp_rdata_o);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rsp_drained: got valid=%b required 0", bus.rsp_valid_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        int bad;
        bad = 0;
        bus.rsp_ready_i = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i < 16) begin
                bus.req_valid_i = 1'b1;
                bus.req_we_i    = 1'b0;
                bus.req_addr_i  = 6'(i);
            end else begin
                drive_idle();
            end
            #1;
            if (i < 16 && bus.req_ready_o !== 1'b1) begin
                if (bad == 0) $display("[TB] FAIL b2b_ready: cycle %0d got %b required 1", i, bus.req_ready_o);
                bad++;
            end
            if (i > 0) begin
                exp = (i - 1 == 5) ? 64'h0000000055667788 : 64'h0;
                if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== exp) begin
                    if (bad == 0)
                        $display("[TB] FAIL b2b_rsp: addr %0d got valid=%b data=%h required 1 %h",
                                 i - 1, bus.rsp_valid_o, bus.rsp_rdata_o, exp);
                    bad++;
                end
            end
        end
        n_tests++;
        if (bad != 0) n_fail++;
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_tail: got valid=%b required 0", bus.rsp_valid_o);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] wd [3];
        wd[0] = D10; wd[1] = D11; wd[2] = D12;
        bus.rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req_valid_i = 1'b1;
            bus.req_we_i    = 1'b1;
            bus.req_addr_i  = 6'(10 + i);
            bus.req_wdata_i = wd[i];
            bus.req_be_i    = 8'hFF;
        end
        @(negedge clk);
        bus.req_we_i = 1'b0;
        bus.req_addr_i = 6'd10;
        #1;
        n_tests++;
        if (bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL bp_c0: got rdy=%b valid=%b required 1 0", bus.req_ready_o, bus.rsp_valid_o);
        end
        @(negedge clk);
        bus.req_addr_i = 6'd11;
        #1;
        n_tests++;
        if (bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== D10) begin
            n_fail++;
            $display("[TB] FAIL bp_c1: got rdy=%b valid=%b data=%h required 1 1 %h",
                     bus.req_ready_o, bus.rsp_valid_o, bus.rsp_rdata_o, D10);
        end
        @(negedge clk);
        bus.req_addr_i = 6'd12;
        #1;
        n_tests++;
        if (bus.req_ready_o !== 1'b0 || bus.sram_cs_o !== 1'b0 || bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== D10) begin
            n_fail++;
            $display("[TB] FAIL bp_full: got rdy=%b cs=%b valid=%b data=%h required 0 0 1 %h",
                     bus.req_ready_o, bus.sram_cs_o, bus.rsp_valid_o, bus.rsp_rdata_o, D10);
        end
        @(negedge clk);
        bus.rsp_ready_i = 1'b1;
        #1;
        n_tests++;
        if (bus.req_ready_o !== 1'b0 || bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== D10) begin
            n_fail++;
            $display("[TB] FAIL bp_hold: got rdy=%b valid=%b data=%h required 0 1 %h",
                     bus.req_ready_o, bus.rsp_valid_o, bus.rsp_rdata_o, D10);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.req_ready_o !== 1'b1 || bus.sram_cs_o !== 1'b1 || bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== D11) begin
            n_fail++;
            $display("[TB] FAIL bp_second: got rdy=%b cs=%b valid=%b data=%h required 1 1 1 %h",
                     bus.req_ready_o, bus.sram_cs_o, bus.rsp_valid_o, bus.rsp_rdata_o, D11);
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_tests++;
        if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== D12) begin
            n_fail++;
            $display("[TB] FAIL bp_third: got valid=%b data=%h required 1 %h", bus.rsp_valid_o, bus.rsp_rdata_o, D12);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bp_drained: got valid=%b rdy=%b required 0 1", bus.rsp_valid_o, bus.req_ready_o);
        end
    endtask

    task automatic test_reset_midop();
        int bad;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= 20; k++) @(negedge clk);
        #1;
        n_tests++;
        if (bus.sram_cs_o !== 1'b1 || bus.sram_addr_o !== 6'd20) begin
            n_fail++;
            $display("[TB] FAIL midfill_addr: got cs=%b addr=%0d required 1 20", bus.sram_cs_o, bus.sram_addr_o);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.sram_cs_o, bus.req_ready_o, bus.rsp_valid_o, bus.init_done_o} !== 4'b0) begin
            n_fail++;
            $display("[TB] FAIL midfill_reset: got cs/rdy/rv/done=%b required 0000",
                     {bus.sram_cs_o, bus.req_ready_o, bus.rsp_valid_o, bus.init_done_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            #1;
            if (bus.sram_cs_o !== 1'b1 || bus.sram_addr_o !== 6'(k)) begin
                if (bad == 0)
                    $display("[TB] FAIL refill: cycle %0d got cs=%b addr=%0d required 1 %0d",
                             k, bus.sram_cs_o, bus.sram_addr_o, k);
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) n_fail++;
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.init_done_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL refill_done: got %b required 1", bus.init_done_o);
        end

        bus.rsp_ready_i = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = 6'd10;
        @(negedge clk);
        bus.req_addr_i  = 6'd11;
        @(negedge clk);
        drive_idle();
        #1;
        n_tests++;
        if (bus.rsp_valid_o !== 1'b1 || bus.req_ready_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL outstanding: got valid=%b rdy=%b required 1 0", bus.rsp_valid_o, bus.req_ready_o);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL outstanding_reset: got valid=%b rdy=%b required 0 0", bus.rsp_valid_o, bus.req_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready_i = 1'b1;
        bad = 0;
        for (int k = 0; k <= DEPTH; k++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid_o !== 1'b0 || bus.sram_cs_o !== 1'b1 || bus.sram_addr_o !== 6'(k % DEPTH)) begin
                if (k < DEPTH || bus.rsp_valid_o !== 1'b0) begin
                    if (bad == 0)
                        $display("[TB] FAIL stale_rsp: cycle %0d got valid=%b cs=%b addr=%0d required valid 0",
                                 k, bus.rsp_valid_o, bus.sram_cs_o, bus.sram_addr_o);
                    bad++;
                end
            end
        end
        n_tests++;
        if (bad != 0) n_fail++;
        n_tests++;
        if (bus.init_done_o !== 1'b1 || bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL final_state: got done=%b rdy=%b valid=%b required 1 1 0",
                     bus.init_done_o, bus.req_ready_o, bus.rsp_valid_o);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_init_fill();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
